// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises reads and writes onto a
// single-port synchronous memory with registered-address read timing.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_ctrl,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // state   | meaning
    // IDLE    | waiting for a request; winner latched on exit
    // ISSUE   | address/data/ctrl presented, memory samples at cycle end
    // CAPTURE | mem_rdata valid for the latched address
    // ACK     | one-cycle ack to the owner, round-robin pointer updated

    localparam logic MEMORY_READ  = 1'b0;
    localparam logic MEMORY_WRITE = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t              state, state_nxt;
    logic                lat_owner;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                last_grant;
    logic                any_req;
    logic                winner;

    assign any_req = req0 | req1;
    // On a tie the port that was not served last wins.
    assign winner  = (req0 && req1) ? ~last_grant : req1;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack0      = (state == ACK) && !lat_owner;
        ack1      = (state == ACK) &&  lat_owner;
        mem_ctrl  = (state == ISSUE && lat_we) ? MEMORY_WRITE : MEMORY_READ;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            lat_owner  <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_grant <= 1'b1;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                lat_owner <= winner;
                lat_we    <= winner ? we1    : we0;
                lat_addr  <= winner ? addr1  : addr0;
                lat_wdata <= winner ? wdata1 : wdata0;
            end
            if (state == CAPTURE && !lat_we) begin
                if (lat_owner) rdata1 <= mem_rdata;
                else           rdata0 <= mem_rdata;
            end
            if (state == ACK) last_grant <= lat_owner;
        end
    end

endmodule
